nand4_sweep_ctrl: RTL and testbench

//  Exhaustive-sweep controller for a 4-input combinational gate unit (NAND4 variants).
//  - Drives the DUV inputs through every vector 0..2^N_IN-1.
//  - Holds each vector for a programmable dwell and samples the DUV output.
//  - Checks each sample against the NAND reference and reports pass/fail, error count and first failing vector.
//  - Sits beside the gate under test; the DUV's o_f is looped back into i_f.

---
 rtl/nand4_sweep_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_nand4_sweep_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand4_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nand4_sweep_ctrl
//
// Exhaustive-sweep controller for a 4-input NAND gate under test. It walks
// o_vec through every vector 0..2^N_IN-1 and holds each one for DWELL_CYCLES
// clocks. On the last dwell clock it samples the looped-back DUV output i_f
// and checks it against the NAND of the vector. It also keeps a mismatch count
// and records the first failing vector.
//
// Optional feature macro: SWEEP_TRUTH_EN
//   defined   : o_truth holds the observed truth table (bit k = i_f for vector k)
//   undefined : no capture register is built and o_truth is tied to 0
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_start       start a sweep (honoured only in IDLE)
//   i_abort       abandon the sweep; wins over i_start and over the final sample
//   i_f           DUV output under check
//   o_vec         DUV input vector (bit N_IN-1 -> a ... bit 0 -> d)
//   o_busy        high while a sweep is running
//   o_done        one-clock pulse after the final sample
//   o_pass        last completed sweep had zero mismatches
//   o_err_cnt     mismatch count of the current/last sweep
//   o_first_fail  vector of the first mismatch (valid when o_err_cnt != 0)
//   o_truth       observed truth table
// -----------------------------------------------------------------------------
module nand4_sweep_ctrl #(
   parameter int N_IN         = 4,
   parameter int DWELL_CYCLES = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic                 i_f,
   output logic [N_IN-1:0]      o_vec,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_pass,
   output logic [N_IN:0]        o_err_cnt,
   output logic [N_IN-1:0]      o_first_fail,
   output logic [(2**N_IN)-1:0] o_truth
);

   // A single-clock dwell still needs a 1-bit counter that never advances.
   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [N_IN-1:0] VEC_LAST   = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DW-1:0]       r_dwell;
   logic [DW-1:0]       w_dwell_nxt;
   logic [N_IN-1:0]     r_vec;
   logic [N_IN-1:0]     w_vec_nxt;
   logic                r_busy;
   logic                w_busy_nxt;
   logic                r_done;
   logic                w_done_nxt;
   logic                r_pass;
   logic                w_pass_nxt;
   logic [N_IN:0]       r_err_cnt;
   logic [N_IN:0]       w_err_nxt;
   logic [N_IN-1:0]     r_first_fail;
   logic [N_IN-1:0]     w_first_nxt;

   logic                w_sample;
   logic                w_mismatch;

`ifdef SWEEP_TRUTH_EN
   logic [(2**N_IN)-1:0] r_truth;
   logic [(2**N_IN)-1:0] w_truth_nxt;
`endif

   // Sample point: the edge that ends the last dwell clock of the current vector.
   assign w_sample   = (r_state == S_RUN) && (r_dwell == DWELL_LAST);
   assign w_mismatch = (i_f != ~(&r_vec));

   // Next-state and next-output logic for the sweep FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_dwell_nxt = r_dwell;
      w_vec_nxt   = r_vec;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_pass_nxt  = r_pass;
      w_err_nxt   = r_err_cnt;
      w_first_nxt = r_first_fail;
`ifdef SWEEP_TRUTH_EN
      w_truth_nxt = r_truth;
`endif
      case (r_state)
         S_IDLE: begin
            // Abort outranks start, so a simultaneous pair leaves us idle.
            if (i_start && !i_abort) begin
               w_state_nxt = S_RUN;
               w_busy_nxt  = 1'b1;
               w_vec_nxt   = {N_IN{1'b0}};
               w_dwell_nxt = {DW{1'b0}};
               w_err_nxt   = {(N_IN+1){1'b0}};
               w_first_nxt = {N_IN{1'b0}};
               w_pass_nxt  = 1'b0;
`ifdef SWEEP_TRUTH_EN
               w_truth_nxt = {(2**N_IN){1'b0}};
`endif
            end else begin
               w_busy_nxt  = 1'b0;
               w_dwell_nxt = {DW{1'b0}};
            end
         end
         S_RUN: begin
            if (i_abort) begin
               // Partial counters are left as they are for inspection.
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
               w_vec_nxt   = {N_IN{1'b0}};
               w_dwell_nxt = {DW{1'b0}};
               w_pass_nxt  = 1'b0;
            end else if (w_sample) begin
               w_dwell_nxt = {DW{1'b0}};
`ifdef SWEEP_TRUTH_EN
               w_truth_nxt[r_vec] = i_f;
`endif
               if (w_mismatch) begin
                  w_err_nxt = r_err_cnt + {{N_IN{1'b0}}, 1'b1};
                  if (r_err_cnt == {(N_IN+1){1'b0}}) begin
                     w_first_nxt = r_vec;
                  end else begin
                     w_first_nxt = r_first_fail;
                  end
               end else begin
                  w_err_nxt = r_err_cnt;
               end
               if (r_vec == VEC_LAST) begin
                  w_state_nxt = S_DONE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_vec_nxt   = {N_IN{1'b0}};
                  w_pass_nxt  = (r_err_cnt == {(N_IN+1){1'b0}}) && !w_mismatch;
               end else begin
                  w_vec_nxt   = r_vec + {{(N_IN-1){1'b0}}, 1'b1};
               end
            end else begin
               w_dwell_nxt = r_dwell + {{(DW-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_vec_nxt   = {N_IN{1'b0}};
            w_dwell_nxt = {DW{1'b0}};
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_dwell      <= {DW{1'b0}};
         r_vec        <= {N_IN{1'b0}};
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_cnt    <= {(N_IN+1){1'b0}};
         r_first_fail <= {N_IN{1'b0}};
      end else begin
         r_state      <= w_state_nxt;
         r_dwell      <= w_dwell_nxt;
         r_vec        <= w_vec_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_pass       <= w_pass_nxt;
         r_err_cnt    <= w_err_nxt;
         r_first_fail <= w_first_nxt;
      end
   end

`ifdef SWEEP_TRUTH_EN
   // Observed truth-table capture register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_truth <= {(2**N_IN){1'b0}};
      end else begin
         r_truth <= w_truth_nxt;
      end
   end

   assign o_truth = r_truth;
`else
   assign o_truth = {(2**N_IN){1'b0}};
`endif

   assign o_vec        = r_vec;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_err_cnt    = r_err_cnt;
   assign o_first_fail = r_first_fail;

endmodule

// File: tb/tb_nand4_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for nand4_sweep_ctrl (N_IN=4, DWELL_CYCLES=4).
// The gate under test is a 16-entry lookup table driven from o_vec. The
// expected sweep results come from scanning that table against NAND4.
// -----------------------------------------------------------------------------
module tb_nand4_sweep_ctrl;

   localparam int N     = 4;
   localparam int DWELL = 4;
   localparam int NV    = 16;
   localparam int LAST  = NV * DWELL;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_start = 1'b0;
   logic          i_abort = 1'b0;
   logic          i_f;
   logic [3:0]    o_vec;
   logic          o_busy;
   logic          o_done;
   logic          o_pass;
   logic [4:0]    o_err_cnt;
   logic [3:0]    o_first_fail;
   logic [15:0]   o_truth;

   logic [15:0]   duv_tab;     // i_f response of the gate under test, per vector
   int            vecs = 0;
   int            errs = 0;

   nand4_sweep_ctrl #(.N_IN(N), .DWELL_CYCLES(DWELL)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (i_start),
      .i_abort      (i_abort),
      .i_f          (i_f),
      .o_vec        (o_vec),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_pass       (o_pass),
      .o_err_cnt    (o_err_cnt),
      .o_first_fail (o_first_fail),
      .o_truth      (o_truth)
   );

   always #5 clk = ~clk;

   assign i_f = duv_tab[o_vec];

   // Expected results after the first nsamp vectors have been sampled.
   function automatic void model(input int nsamp, output int err,
                                 output logic [3:0] first, output logic [15:0] truth);
      err = 0; first = 4'd0; truth = 16'd0;
      for (int v = 0; v < nsamp; v++) begin
         logic nand_ref;
         nand_ref = (v != NV - 1);
         truth[v] = duv_tab[v];
         if (duv_tab[v] !== nand_ref) begin
            if (err == 0) first = v[3:0];
            err++;
         end
      end
`ifndef SWEEP_TRUTH_EN
      truth = 16'd0;
`endif
   endfunction

   // One full or partial sweep; pulse_at/abort_at/rst_at are edge numbers after start (0 = none).
   task automatic run_sweep(input int pulse_at, input int abort_at, input int rst_at);
      int          nsamp, e_err;
      logic [3:0]  e_first;
      logic [15:0] e_truth;
      logic [5:0]  exp_bdv, got_bdv;
      @(negedge clk); i_start = 1'b1;
      @(posedge clk); #1; i_start = 1'b0;
      vecs++;
      if ({o_busy, o_done, o_vec, o_err_cnt, o_first_fail, o_pass, o_truth} !== {1'b1, 1'b0, 4'd0, 5'd0, 4'd0, 1'b0, 16'd0}) begin
         errs++;
         $display("FAIL start_state: busy=%b done=%b vec=%h err=%0d first=%h pass=%b truth=%h, want busy=1 rest 0",
                  o_busy, o_done, o_vec, o_err_cnt, o_first_fail, o_pass, o_truth);
      end
      for (int n = 1; n <= LAST; n++) begin
         @(negedge clk);
         i_start = (n == pulse_at);
         i_abort = (n == abort_at);
         @(posedge clk); #1;
         i_start = 1'b0; i_abort = 1'b0;
         if (n == abort_at) begin
            nsamp = (abort_at - 1) / DWELL;
            model(nsamp, e_err, e_first, e_truth);
            vecs++;
            if ({o_busy, o_done, o_vec, o_pass} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin
               errs++;
               $display("FAIL abort_state n=%0d: busy=%b done=%b vec=%h pass=%b, want all 0", n, o_busy, o_done, o_vec, o_pass);
            end
            vecs++;
            if (o_err_cnt !== 5'(e_err) || o_first_fail !== e_first || o_truth !== e_truth) begin
               errs++;
               $display("FAIL abort_counters: err=%0d first=%h truth=%h, want err=%0d first=%h truth=%h",
                        o_err_cnt, o_first_fail, o_truth, e_err, e_first, e_truth);
            end
            for (int k = 0; k < 6; k++) begin
               @(posedge clk); #1;
               vecs++;
               if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                  errs++;
                  $display("FAIL abort_no_done k=%0d: done=%b busy=%b, want 0 0", k, o_done, o_busy);
               end
            end
            return;
         end
         exp_bdv = (n < LAST) ? {1'b1, 1'b0, 4'(n / DWELL)} : {1'b0, 1'b1, 4'd0};
         got_bdv = {o_busy, o_done, o_vec};
         vecs++;
         if (got_bdv !== exp_bdv) begin
            errs++;
            $display("FAIL run_timing n=%0d: busy/done/vec=%b, want %b", n, got_bdv, exp_bdv);
         end
         if (n == rst_at) begin
            #2 rst = 1'b1;
            #1;
            vecs++;
            if ({o_busy, o_done, o_vec, o_err_cnt, o_first_fail, o_pass, o_truth} !== 32'd0) begin
               errs++;
               $display("FAIL async_reset: busy=%b done=%b vec=%h err=%0d first=%h pass=%b truth=%h, want all 0",
                        o_busy, o_done, o_vec, o_err_cnt, o_first_fail, o_pass, o_truth);
            end
            repeat (2) @(posedge clk);
            @(negedge clk); rst = 1'b0;
            return;
         end
      end
      model(NV, e_err, e_first, e_truth);
      vecs++;
      if (o_err_cnt !== 5'(e_err) || o_first_fail !== e_first || o_truth !== e_truth || o_pass !== (e_err == 0)) begin
         errs++;
         $display("FAIL sweep_result: err=%0d first=%h truth=%h pass=%b, want err=%0d first=%h truth=%h pass=%b",
                  o_err_cnt, o_first_fail, o_truth, o_pass, e_err, e_first, e_truth, (e_err == 0));
      end
      @(posedge clk); #1;
      vecs++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_pass !== (e_err == 0)) begin
         errs++;
         $display("FAIL done_pulse_end: done=%b busy=%b pass=%b, want 0 0 %b", o_done, o_busy, o_pass, (e_err == 0));
      end
   endtask

   function automatic logic [15:0] nand_table();
      return 16'h7FFF;
   endfunction

   task automatic test_reset();
      repeat (2) @(posedge clk); #1;
      vecs++;
      if ({o_busy, o_done, o_vec, o_err_cnt, o_first_fail, o_pass, o_truth} !== 32'd0) begin
         errs++;
         $display("FAIL reset_values: busy=%b done=%b vec=%h err=%0d first=%h pass=%b truth=%h, want all 0",
                  o_busy, o_done, o_vec, o_err_cnt, o_first_fail, o_pass, o_truth);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      vecs++;
      if (o_busy !== 1'b0 || o_vec !== 4'd0) begin
         errs++;
         $display("FAIL idle_after_reset: busy=%b vec=%h, want 0 0", o_busy, o_vec);
      end
   endtask

   task automatic test_correct();
      duv_tab = nand_table();
      run_sweep(0, 0, 0);
      vecs++;
      if (o_pass !== 1'b1 || o_err_cnt !== 5'd0) begin
         errs++;
         $display("FAIL correct_nand: pass=%b err=%0d, want 1 0", o_pass, o_err_cnt);
      end
   endtask

   task automatic test_stuck1();
      duv_tab = 16'hFFFF;
      run_sweep(0, 0, 0);
      vecs++;
      if (o_err_cnt !== 5'd1 || o_first_fail !== 4'hF || o_pass !== 1'b0) begin
         errs++;
         $display("FAIL stuck1: err=%0d first=%h pass=%b, want 1 f 0", o_err_cnt, o_first_fail, o_pass);
      end
   endtask

   task automatic test_stuck0();
      duv_tab = 16'h0000;
      run_sweep(0, 0, 0);
      vecs++;
      if (o_err_cnt !== 5'd15 || o_first_fail !== 4'h0 || o_pass !== 1'b0) begin
         errs++;
         $display("FAIL stuck0: err=%0d first=%h pass=%b, want 15 0 0", o_err_cnt, o_first_fail, o_pass);
      end
   endtask

   task automatic test_all_wrong();
      duv_tab = 16'h8000;
      run_sweep(0, 0, 0);
      vecs++;
      if (o_err_cnt !== 5'd16 || o_first_fail !== 4'h0) begin
         errs++;
         $display("FAIL all_wrong: err=%0d first=%h, want 16 0", o_err_cnt, o_first_fail);
      end
   endtask

   task automatic test_random_faults();
      for (int i = 0; i < 5; i++) begin
         duv_tab = 16'($urandom);
         run_sweep(0, 0, 0);
      end
   endtask

   task automatic test_restart_ignored();
      duv_tab = nand_table();
      run_sweep(20, 0, 0);
      duv_tab = 16'($urandom);
      run_sweep(0, 0, 0);
   endtask

   task automatic test_abort();
      duv_tab = 16'($urandom);
      run_sweep(0, 30, 0);
      duv_tab = 16'($urandom);
      run_sweep(0, LAST, 0);
      duv_tab = 16'($urandom);
      run_sweep(0, int'($urandom_range(1, LAST - 1)), 0);
      duv_tab = nand_table();
      run_sweep(0, 0, 0);
   endtask

   task automatic test_async_reset();
      duv_tab = 16'h0F0F;
      run_sweep(0, 0, 37);
      duv_tab = nand_table();
      run_sweep(0, 0, 0);
   endtask

   initial begin
      duv_tab = nand_table();
      test_reset();
      test_correct();
      test_stuck1();
      test_stuck0();
      test_all_wrong();
      test_random_faults();
      test_restart_ignored();
      test_abort();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
